// File: rtl/garnet_param.sv
// Shared GLB config-bus types, address-map constants and the AXI-Lite address decoder.
package garnet_param;

  localparam int unsigned CFG_ADDR_WIDTH = 13;
  localparam int unsigned CFG_TILE_WIDTH = 4;
  localparam int unsigned CFG_SPACE_BIT  = 12;
  localparam int unsigned CFG_TILE_LSB   = 8;
  localparam int unsigned CFG_REG_LSB    = 2;
  localparam int unsigned CFG_REG_WIDTH  = 6;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP
  } glb_axil_state_e;

  typedef struct packed {
    logic                      err;
    logic [CFG_TILE_WIDTH-1:0] tile;
    logic [CFG_REG_WIDTH-1:0]  reg_idx;
  } glb_cfg_dec_t;

  // Word-aligned addresses below the upper half map to {tile, register}; anything else errors.
  function automatic glb_cfg_dec_t glb_cfg_decode(input logic [CFG_ADDR_WIDTH-1:0] addr);
    glb_cfg_dec_t dec;
    dec.err     = addr[CFG_SPACE_BIT] | (addr[1:0] != 2'b00);
    dec.tile    = addr[CFG_TILE_LSB +: CFG_TILE_WIDTH];
    dec.reg_idx = addr[CFG_REG_LSB +: CFG_REG_WIDTH];
    return dec;
  endfunction

endpackage

// File: rtl/glb_axil_cfg_responder.sv
// AXI4-Lite responder for the host config port: one outstanding transaction,
// each converted into a single-beat strobe on the GLB tile config bus.
// Optional read-return timeout is built when GLB_AXIL_RD_TIMEOUT_EN is defined.
module glb_axil_cfg_responder
  import garnet_param::*;
#(
  parameter int unsigned NUM_GLB_TILES  = 16,
  parameter int unsigned AXI_ADDR_WIDTH = 13,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned RD_TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [AXI_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  output logic                          cfg_wr_en,
  output logic                          cfg_rd_en,
  output logic [$clog2(NUM_GLB_TILES)-1:0] cfg_tile_id,
  output logic [5:0]                    cfg_reg_addr,
  output logic [AXI_DATA_WIDTH-1:0]     cfg_wr_data,
  input  logic                          cfg_rd_data_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     cfg_rd_data
);

  localparam int unsigned TILE_W = $clog2(NUM_GLB_TILES);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  glb_axil_state_e             state;
  logic                        aw_held;
  logic                        w_held;
  logic                        prefer_wr;
  logic                        wr_err_q;
  logic                        rd_err_q;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]           w_strb_q;

  logic                        idle;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic                        wr_go;
  logic                        wr_err;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_eff;
  logic [AXI_DATA_WIDTH-1:0]   w_data_eff;
  logic [STRB_W-1:0]           w_strb_eff;
  glb_cfg_dec_t                wr_dec;
  glb_cfg_dec_t                rd_dec;

`ifdef GLB_AXIL_RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] rd_cnt;
`else
  logic rd_timeout_unused;
  assign rd_timeout_unused = (RD_TIMEOUT == 0);
`endif

  // Readies come straight from state so a contested AR/AW pair is arbitrated in the same cycle;
  // the losing side is held off so only one transaction is ever accepted.
  assign idle    = (state == ST_IDLE);
  assign arready = rst_n && idle && !aw_held && !w_held && !(awvalid && prefer_wr);
  assign ar_hs   = arvalid && arready;
  assign awready = rst_n && idle && !aw_held && !ar_hs;
  assign wready  = rst_n && idle && !w_held && !ar_hs;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Merge freshly handshaken and previously held write halves, then decode.
  always_comb begin
    aw_addr_eff = aw_held ? aw_addr_q : awaddr;
    w_data_eff  = w_held  ? w_data_q  : wdata;
    w_strb_eff  = w_held  ? w_strb_q  : wstrb;
    wr_go       = idle && (aw_held || aw_hs) && (w_held || w_hs);
    wr_dec      = glb_cfg_decode(CFG_ADDR_WIDTH'(aw_addr_eff));
    rd_dec      = glb_cfg_decode(CFG_ADDR_WIDTH'(araddr));
    wr_err      = wr_dec.err || (w_strb_eff != {STRB_W{1'b1}});
  end

  // Transaction FSM with capture registers and registered response/config outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      prefer_wr    <= 1'b1;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid       <= 1'b0;
      bresp        <= 2'b00;
      rvalid       <= 1'b0;
      rresp        <= 2'b00;
      rdata        <= '0;
      cfg_wr_en    <= 1'b0;
      cfg_rd_en    <= 1'b0;
      cfg_tile_id  <= '0;
      cfg_reg_addr <= '0;
      cfg_wr_data  <= '0;
`ifdef GLB_AXIL_RD_TIMEOUT_EN
      rd_cnt       <= '0;
`endif
    end else begin
      cfg_wr_en <= 1'b0;
      cfg_rd_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (awvalid && arvalid && !aw_held && !w_held) begin
            prefer_wr <= !prefer_wr;
          end
          if (wr_go) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_err_q <= wr_err;
            state    <= ST_WR_ISSUE;
            if (!wr_err) begin
              cfg_wr_en    <= 1'b1;
              cfg_tile_id  <= TILE_W'(wr_dec.tile);
              cfg_reg_addr <= wr_dec.reg_idx;
              cfg_wr_data  <= w_data_eff;
            end
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= awaddr;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= wdata;
              w_strb_q <= wstrb;
            end
          end
          if (ar_hs) begin
            rd_err_q <= rd_dec.err;
            state    <= ST_RD_ISSUE;
            if (!rd_dec.err) begin
              cfg_rd_en    <= 1'b1;
              cfg_tile_id  <= TILE_W'(rd_dec.tile);
              cfg_reg_addr <= rd_dec.reg_idx;
            end
          end
        end
        ST_WR_ISSUE: begin
          bvalid <= 1'b1;
          bresp  <= wr_err_q ? AXIL_SLVERR : AXIL_OKAY;
          state  <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          if (rd_err_q) begin
            rvalid <= 1'b1;
            rresp  <= AXIL_SLVERR;
            rdata  <= '0;
            state  <= ST_RD_RESP;
          end else begin
            state  <= ST_RD_WAIT;
`ifdef GLB_AXIL_RD_TIMEOUT_EN
            rd_cnt <= '0;
`endif
          end
        end
        ST_RD_WAIT: begin
          if (cfg_rd_data_valid) begin
            rvalid <= 1'b1;
            rresp  <= AXIL_OKAY;
            rdata  <= cfg_rd_data;
            state  <= ST_RD_RESP;
          end
`ifdef GLB_AXIL_RD_TIMEOUT_EN
          else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            rvalid <= 1'b1;
            rresp  <= AXIL_SLVERR;
            rdata  <= AXI_DATA_WIDTH'(32'hDEAD_BEEF);
            state  <= ST_RD_RESP;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
`endif
        end
        ST_RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
